// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: blank pattern, hex glyph
// table (active-low, seg[0]=CA .. seg[6]=CG) and the slot-phase enum.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the glyph for hex digit n; the concatenation lists F down to 0.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {BLANK, ON} phase_e;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Upstream write port (load strobe + nibble word) and display pins.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [7:0]              an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_start;

  modport master (output load, value, dp_in, digit_en,
                  input  an, seg, dp, frame_start);
  modport slave  (input  load, value, dp_in, digit_en,
                  output an, seg, dp, frame_start);
endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = hex_glyph(nib_i);
endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner with pending/shadow double buffering; new data
// is committed only at the end of the last digit slot so frames never tear.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 500
) (
  input logic              clk,
  input logic              rst,
  seg7_scan_driver_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  phase_e        phase_q, phase_d;

  logic [NUM_DIGITS-1:0][3:0] val_p_q, val_s_q;
  logic [NUM_DIGITS-1:0]      dp_p_q, dp_s_q, en_p_q, en_s_q;
  logic                       pend_v_q;

  logic [7:0] an_q, an_d;
  logic [6:0] seg_q, seg_d, seg_dec;
  logic       dp_q, dp_d, fs_q;
  logic       tick, last, commit;
  logic [3:0] nib;

  assign tick   = (cnt_q == CW'(REFRESH_DIV - 1));
  assign last   = (idx_q == IW'(NUM_DIGITS - 1));
  // A load on the commit cycle itself is forwarded straight into shadow.
  assign commit = tick && last && (pend_v_q || bus.load);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = last ? '0 : idx_q + 1'b1;
    // phase_q tracks cnt_q, so it is computed from the next count.
    phase_d = (int'(cnt_d) < BLANK_CYCLES) ? BLANK : ON;
  end

  assign nib = val_s_q[idx_q];

  hex_to_seg7 u_dec (
    .nib_i (nib),
    .seg_o (seg_dec)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (phase_q == ON && en_s_q[idx_q]) begin
      an_d[idx_q] = 1'b0;
      seg_d       = seg_dec;
      dp_d        = ~dp_s_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      phase_q  <= (BLANK_CYCLES > 0) ? BLANK : ON;
      val_p_q  <= '0;
      dp_p_q   <= '0;
      en_p_q   <= '0;
      val_s_q  <= '0;
      dp_s_q   <= '0;
      en_s_q   <= '0;
      pend_v_q <= 1'b0;
      an_q     <= '1;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      if (bus.load) begin
        val_p_q <= bus.value;
        dp_p_q  <= bus.dp_in;
        en_p_q  <= bus.digit_en;
      end
      if (commit) begin
        val_s_q <= bus.load ? bus.value    : val_p_q;
        dp_s_q  <= bus.load ? bus.dp_in    : dp_p_q;
        en_s_q  <= bus.load ? bus.digit_en : en_p_q;
      end
      pend_v_q <= commit ? 1'b0 : (bus.load | pend_v_q);
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      fs_q     <= (cnt_q == '0) && (idx_q == '0);
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 8-cycle slots, 2 blank cycles.
module tb_seg7_scan_driver;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One record per 32-cycle frame: up to two loads (position -1 = none) and
  // the per-digit pins expected during the ON part of each slot.
  typedef struct {
    int               pa;
    logic [15:0]      va;
    logic [3:0]       da, ea;
    int               pb;
    logic [15:0]      vb;
    logic [3:0]       db, eb;
    logic [3:0][7:0]  an;
    logic [3:0][6:0]  seg;
    logic [3:0]       dp;
  } frame_t;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } hex_t;

  frame_t ft[11];
  hex_t   hx[16];
  int     errors = 0;
  int     checks = 0;
  int     pos;

  task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pos = (pos + 1) % 32;
  endtask

  task automatic wait_pos(input int p);
    for (int n = 0; n < 40 && pos != p; n++) step();
  endtask

  task automatic run_frame(input int f);
    int d, c;
    logic [16:0] want;
    for (int p = 0; p < 32; p++) begin
      if (ft[f].pa == p) begin
        bus.load = 1'b1; bus.value = ft[f].va; bus.dp_in = ft[f].da; bus.digit_en = ft[f].ea;
      end else if (ft[f].pb == p) begin
        bus.load = 1'b1; bus.value = ft[f].vb; bus.dp_in = ft[f].db; bus.digit_en = ft[f].eb;
      end
      step();
      bus.load = 1'b0;
      d = p / 8;
      c = p % 8;
      if (c < 2) want = {8'hFF, 7'h7F, 1'b1, (p == 0)};
      else       want = {ft[f].an[d], ft[f].seg[d], ft[f].dp[d], 1'b0};
      chk($sformatf("frame%0d pos%0d {an,seg,dp,fs}", f, p),
          {bus.an, bus.seg, bus.dp, bus.frame_start}, want);
      if (ft[f].pa == 31 && p == 31)
        chk("pend_v after load+commit", {16'h0, dut.pend_v_q}, 17'h0);
    end
  endtask

  initial begin
    // blank frame / F821 scan / A-only / 1010-blanked / 0123 with all dp lit
    ft[0]  = '{10, 16'hF821, 4'b0001, 4'hF, -1, 16'h0, 4'h0, 4'h0,
               32'hFFFFFFFF, 28'hFFFFFFF, 4'hF};
    ft[1]  = '{-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0,
               {8'hF7, 8'hFB, 8'hFD, 8'hFE}, {7'h0E, 7'h00, 7'h24, 7'h79}, 4'b1110};
    ft[2]  = '{11, 16'h0000, 4'h0, 4'hF, 20, 16'hAAAA, 4'h0, 4'hF,
               {8'hF7, 8'hFB, 8'hFD, 8'hFE}, {7'h0E, 7'h00, 7'h24, 7'h79}, 4'b1110};
    ft[3]  = '{-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0,
               {8'hF7, 8'hFB, 8'hFD, 8'hFE}, {7'h08, 7'h08, 7'h08, 7'h08}, 4'hF};
    ft[4]  = '{5, 16'h8421, 4'h0, 4'b1010, -1, 16'h0, 4'h0, 4'h0,
               {8'hF7, 8'hFB, 8'hFD, 8'hFE}, {7'h08, 7'h08, 7'h08, 7'h08}, 4'hF};
    ft[5]  = '{-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0,
               {8'hF7, 8'hFF, 8'hFD, 8'hFF}, {7'h00, 7'h7F, 7'h24, 7'h7F}, 4'hF};
    ft[6]  = '{31, 16'h0123, 4'hF, 4'hF, -1, 16'h0, 4'h0, 4'h0,
               {8'hF7, 8'hFF, 8'hFD, 8'hFF}, {7'h00, 7'h7F, 7'h24, 7'h7F}, 4'hF};
    ft[7]  = '{-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0,
               {8'hF7, 8'hFB, 8'hFD, 8'hFE}, {7'h40, 7'h79, 7'h24, 7'h30}, 4'h0};
    ft[8]  = ft[7];
    ft[9]  = '{-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0,
               32'hFFFFFFFF, 28'hFFFFFFF, 4'hF};
    ft[10] = ft[9];

    hx = '{'{4'h0, 7'h40}, '{4'h1, 7'h79}, '{4'h2, 7'h24}, '{4'h3, 7'h30},
           '{4'h4, 7'h19}, '{4'h5, 7'h12}, '{4'h6, 7'h02}, '{4'h7, 7'h78},
           '{4'h8, 7'h00}, '{4'h9, 7'h10}, '{4'hA, 7'h08}, '{4'hB, 7'h03},
           '{4'hC, 7'h46}, '{4'hD, 7'h21}, '{4'hE, 7'h06}, '{4'hF, 7'h0E}};

    rst = 1'b1;
    bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.digit_en = '0;
    pos = 0;
    repeat (3) step();
    chk("reset pins", {bus.an, bus.seg, bus.dp, bus.frame_start}, {8'hFF, 7'h7F, 1'b1, 1'b0});

    rst = 1'b0;
    pos = 31;
    for (int f = 0; f <= 8; f++) run_frame(f);

    // Every glyph: load on the commit cycle, look at digit 0 in the next slot.
    for (int i = 0; i < 16; i++) begin
      wait_pos(30);
      bus.load = 1'b1; bus.value = {4{hx[i].nib}}; bus.dp_in = 4'h0; bus.digit_en = 4'b0001;
      step();
      bus.load = 1'b0;
      repeat (3) step();
      chk($sformatf("glyph %h", hx[i].nib), {bus.an, bus.seg, bus.dp, bus.frame_start},
          {8'hFE, hx[i].seg, 1'b1, 1'b0});
    end

    // Reset during digit-2 ON with data pending, plus a load while in reset.
    wait_pos(30);
    bus.load = 1'b1; bus.value = 16'h0123; bus.dp_in = 4'h0; bus.digit_en = 4'hF;
    step();
    bus.load = 1'b0;
    wait_pos(2);
    bus.load = 1'b1; bus.value = 16'hFFFF;
    step();
    bus.load = 1'b0;
    wait_pos(19);
    chk("digit2 before reset", {bus.an, bus.seg, bus.dp, bus.frame_start}, {8'hFB, 7'h79, 1'b1, 1'b0});
    rst = 1'b1;
    step();
    chk("blank after mid-scan reset", {bus.an, bus.seg, bus.dp, bus.frame_start},
        {8'hFF, 7'h7F, 1'b1, 1'b0});
    bus.load = 1'b1; bus.value = 16'h1111; bus.dp_in = 4'hF; bus.digit_en = 4'hF;
    step();
    bus.load = 1'b0;
    step();
    rst = 1'b0;
    pos = 31;
    run_frame(9);
    run_frame(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed 7-segment display driver for the Nexys4 DDR eight-digit display. It sits directly downstream of the switch-driven adder datapath and shows its operands and sum as hex digits instead of raw LEDs. Upstream logic writes a packed nibble word with a `load` strobe. The block double-buffers that word, commits it only at frame boundaries so digits never tear, and scans the digits with an anti-ghosting blank gap.

## Interface
- `NUM_DIGITS`, 8: digits scanned, legal range 1..8.
- `REFRESH_DIV`, 100000: clocks per digit slot (1 kHz slot rate at 100 MHz). Must be ≥ `BLANK_CYCLES`+2.
- `BLANK_CYCLES`, 500: clocks at the start of each slot with all anodes off. 0 is legal.

Ports:
- `clk` in 1: 100 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: one-cycle strobe that captures `value`, `dp_in` and `digit_en` into the pending buffer.
- `value` in 4·NUM_DIGITS: hex nibble per digit. Digit i is `value[4i+3:4i]`.
- `dp_in` in NUM_DIGITS: decimal point per digit, 1 = lit.
- `digit_en` in NUM_DIGITS: 0 = digit blanked.
- `an` out 8: anodes, active-low. Bits at NUM_DIGITS and above are held at 1.
- `seg` out 7: cathodes, active-low. `seg[0]` = CA … `seg[6]` = CG.
- `dp` out 1: decimal point cathode, active-low.
- `frame_start` out 1: one-cycle pulse, aligned with the pins, on the first cycle of each digit-0 slot.

## Operation
- Prescaler `cnt` counts 0..REFRESH_DIV-1 and wraps. `tick` = (cnt == REFRESH_DIV-1).
- Digit index `idx` advances on `tick` and wraps from NUM_DIGITS-1 to 0.
- Slot phase (state machine):
  - BLANK: cnt < BLANK_CYCLES. `an` = all 1, `seg` = 7'h7F, `dp` = 1.
  - ON: all remaining cycles of the slot.
  - Transitions depend only on `cnt`.
- In ON, when `digit_en_s[idx]` = 1:
  - `an` = ~(1<<idx).
  - `seg` = hex decode of shadow nibble `idx`.
  - `dp` = ~`dp_s[idx]`.
- In ON, when `digit_en_s[idx]` = 0: outputs are the same as BLANK.
- Hex decode values: 0→7'h40, 1→7'h79, 2→7'h24, 8→7'h00, A→7'h08, F→7'h0E. The full 16-entry table lives in the package.
- Buffering:
  - `load` writes the pending buffer and sets `pend_v`. The last load before a commit wins.
  - Commit happens on `tick` while idx == NUM_DIGITS-1 and `pend_v` = 1. Pending is copied to shadow and `pend_v` is cleared, so the next frame starts from digit 0 with the new data.
  - If `load` and commit occur in the same cycle, the loaded data goes straight to shadow and `pend_v` ends 0.
  - Without a commit, the shadow buffer holds its contents indefinitely.
- Reset values:
  - Counters: `cnt` = 0, `idx` = 0.
  - Buffers: shadow and pending all 0, so `digit_en_s` = 0 and the display is blank. `pend_v` = 0.
  - Outputs: `an` = 8'hFF, `seg` = 7'h7F, `dp` = 1, `frame_start` = 0.
- Reset mid-scan: pins go blank on the next cycle and pending data is discarded. A `load` in a cycle with `rst` high is ignored.

## Timing
- All outputs are registered. Pins lag internal (`cnt`, `idx`, shadow) state by exactly 1 cycle.
- After the `rst`-low edge, the first digit-0 segment drive appears on the pins BLANK_CYCLES+1 cycles later.
- Slot length = REFRESH_DIV cycles. Frame length = NUM_DIGITS·REFRESH_DIV cycles.
- Load-to-display latency:
  - Worst case: one full frame plus BLANK_CYCLES+1.
  - Best case: the load lands on the commit cycle, giving BLANK_CYCLES+2.
- `frame_start` period = NUM_DIGITS·REFRESH_DIV exactly. The first pulse occurs 1 cycle after reset release.

## Structure
- Package `seg7_pkg` holds:
  - `SEG_BLANK` = 7'h7F.
  - The 16-entry hex→segment constant table.
  - The slot-phase enum {BLANK, ON}.
- Sub-module `hex_to_seg7`: combinational nibble→segment decoder that reads the package table.
- Top level contains the prescaler, digit counter, pending/shadow buffers, phase logic and output registers.

## Test plan
Override parameters to NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 unless a scenario says otherwise.
- **Reset:** hold `rst` 3 cycles → `an` = 8'hFF, `seg` = 7'h7F, `dp` = 1. After release, pins stay blank for a full frame because `digit_en_s` = 0.
- **Basic scan:** `load` with value = 16'hF821, dp_in = 4'b0001, digit_en = 4'hF. After commit:
  - Each 8-cycle slot shows 2 blank cycles, then 6 cycles of the digit.
  - Sequence: `an` = 8'hFE with `seg` = 7'h79 and `dp` = 0; then 8'hFD/7'h24; then 8'hFB/7'h00; then 8'hF7/7'h0E.
  - Bits 7:4 of `an` stay 1.
- **Tear-free update:** load 16'h0000 mid-frame (digit 1), then load 16'hAAAA before the frame ends → digits 2 and 3 still show the old value. The next frame shows only A (7'h08); 16'h0000 is never displayed.
- **Simultaneous load/commit:** assert `load` on the tick with idx = 3 → the new data appears in the very next digit-0 slot and `pend_v` = 0.
- **Blanking:** digit_en = 4'b1010 → slots 0 and 2 keep `an` = 8'hFF. `frame_start` pulses every 32 cycles.
- **Reset mid-scan:** assert `rst` during a digit-2 ON phase with a pending load → pins blank next cycle. After release the display is blank and the pending data is never shown.
